equalization_sequencer: RTL and testbench
=========================================

# equalization_sequencer

Top-level phase controller for the histogram-equalization engine. It launches the histogram, CDF and output pipeline stages in order, waits for each stage's done, and watches each phase with a timeout. It snoops the CDF write stream to produce the `CdfMin` operand consumed by the output pipeline, and reports busy/done/error plus a run cycle count.

## Interface
- `TIMEOUT`, default 65536: maximum cycles permitted in any single WAIT state before the error state is entered.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `go` in 1: run request, sampled only in IDLE or ERROR.
- `hist_start` out 1: one-cycle launch pulse to the histogram stage.
- `hist_done` in 1: histogram stage finished.
- `cdf_start` out 1: one-cycle launch pulse to the CDF stage.
- `cdf_done` in 1: CDF stage finished.
- `cdf_valid` in 1: CDF stage is writing `cdf_value` this cycle.
- `cdf_value` in 8: CDF entry being written.
- `out_start` out 1: one-cycle launch pulse to the output pipeline (drives its `start`).
- `out_done` in 1: output pipeline finished.
- `CdfMin` out 8: minimum non-zero CDF value of the current run.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at successful run end.
- `error` out 1: sticky timeout flag.
- `cycle_count` out 32: cycles consumed by the current or last run.

## Operation
- States: IDLE, HIST_START, HIST_WAIT, CDF_START, CDF_WAIT, OUT_START, OUT_WAIT, DONE, ERROR.
- Transitions:
  - IDLE/ERROR + `go` → HIST_START.
  - HIST_START → HIST_WAIT.
  - HIST_WAIT + `hist_done` → CDF_START.
  - CDF_START → CDF_WAIT.
  - CDF_WAIT + `cdf_done` → OUT_START.
  - OUT_START → OUT_WAIT.
  - OUT_WAIT + `out_done` → DONE.
  - DONE → IDLE unconditionally.
  - Any WAIT with timer = TIMEOUT-1 and no done → ERROR.
- All outputs are registered state decodes.
  - `hist_start`, `cdf_start` and `out_start` are high only in their START states, so each is exactly one cycle wide.
  - `busy` is high in every state except IDLE and ERROR.
  - `done` is high only in DONE.
- Done inputs are sampled only in the matching WAIT state. A done asserted during a START state, or in a non-matching state, is ignored.
- `go` while `busy` is ignored. `go` accepted from ERROR clears `error` and starts a new run.
- Phase timer: 32-bit, cleared on entry to each WAIT state, increments every WAIT cycle.
  - If the done input and timer = TIMEOUT-1 occur in the same cycle, done wins.
  - In ERROR: `error` = 1, `busy` = 0, all start pulses low.
- CdfMin tracking:
  - Set to 8'hFF in CDF_START.
  - In CDF_WAIT, when `cdf_valid`, `cdf_value` != 0 and `cdf_value` < `CdfMin`, load `cdf_value`.
  - Frozen in all other states, so it is stable through OUT_START and OUT_WAIT.
  - If no non-zero value is seen, it remains 8'hFF.
  - A zero `cdf_value` never updates it.
- `cycle_count`:
  - Cleared to 0 in the cycle `go` is accepted.
  - Increments in every state from HIST_START through OUT_WAIT inclusive. Frozen in DONE, IDLE and ERROR.
  - Saturates at 32'hFFFFFFFF.
- Reset (any state, mid-run included) → IDLE.
  - All outputs 0 except `CdfMin` = 8'hFF; timer = 0.
  - Reset dominates a simultaneous `go` or done.

## Timing
- `go` high at edge 0 (IDLE) → `hist_start` high in cycle 1, `busy` high from cycle 1.
- Done sampled in cycle k of a WAIT state → next START pulse in cycle k+1.
- `out_done` sampled in cycle m → `done` high in cycle m+1, IDLE in cycle m+2, `busy` low from m+2.
- Minimum run with every done asserted on the first WAIT cycle: `go` at cycle 0, pulses at cycles 1, 3 and 5, `done` at cycle 7, `cycle_count` = 6.
- Timeout: entering WAIT at cycle w with no done → ERROR at cycle w+TIMEOUT, `error` visible that cycle.
- New `CdfMin` visible the cycle after the qualifying `cdf_valid`.

## Test plan
- Nominal run, each done returned 3 cycles after its start pulse:
  - Starts in cycles 1, 5 and 9; `done` in cycle 13; `cycle_count` = 12; `busy` cycles 1–13.
- CdfMin tracking: `cdf_value` sequence 0, 0, 40, 17, 17, 200 with `cdf_valid` during CDF_WAIT, plus 5 presented with `cdf_valid` low:
  - `CdfMin` = 17 at `out_start`.
  - A run with all-zero values → 8'hFF.
- Spurious dones:
  - `hist_done` held high through HIST_START, and `cdf_done` pulsed during HIST_WAIT → neither is acted on until its matching WAIT state.
  - `go` mid-run → ignored.
- Timeout, TIMEOUT = 16, `cdf_done` never asserted:
  - ERROR 16 cycles after CDF_WAIT entry; `error` = 1, `busy` = 0.
  - A subsequent `go` clears `error` and restarts at HIST_START.
  - Done arriving exactly at timer 15 → no error.
- Reset during OUT_WAIT with `out_done` high the same cycle:
  - IDLE, no `done` pulse, `CdfMin` = 8'hFF, `cycle_count` = 0.
  - Next run behaves nominally.

Source files
------------

// File: rtl/equalization_sequencer.sv
// equalization_sequencer: phase controller for the histogram-equalization engine.
// Launches the histogram, CDF and output stages in turn, guards each wait with a
// timeout, tracks the smallest non-zero CDF entry, and counts run cycles.
module equalization_sequencer #(
  parameter int unsigned TIMEOUT = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  output logic        hist_start,
  input  logic        hist_done,
  output logic        cdf_start,
  input  logic        cdf_done,
  input  logic        cdf_valid,
  input  logic [7:0]  cdf_value,
  output logic        out_start,
  input  logic        out_done,
  output logic [7:0]  CdfMin,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] cycle_count
);

  typedef enum logic [3:0] {
    IDLE,
    HIST_START,
    HIST_WAIT,
    CDF_START,
    CDF_WAIT,
    OUT_START,
    OUT_WAIT,
    DONE,
    ERROR
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] phase_timer;
  logic        timer_expired;
  logic        go_accepted;
  logic        in_run;

  assign timer_expired = (phase_timer == TIMER_LAST);
  assign go_accepted   = ((state == IDLE) || (state == ERROR)) && go;
  assign in_run        = (state == HIST_START) || (state == HIST_WAIT) ||
                         (state == CDF_START)  || (state == CDF_WAIT)  ||
                         (state == OUT_START)  || (state == OUT_WAIT);

  // State register; reset returns to IDLE from anywhere, even mid-run.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a done input only counts in its own WAIT state and beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ERROR: if (go) state_next = HIST_START;
      HIST_START:  state_next = HIST_WAIT;
      HIST_WAIT: begin
        if (hist_done)          state_next = CDF_START;
        else if (timer_expired) state_next = ERROR;
      end
      CDF_START:   state_next = CDF_WAIT;
      CDF_WAIT: begin
        if (cdf_done)           state_next = OUT_START;
        else if (timer_expired) state_next = ERROR;
      end
      OUT_START:   state_next = OUT_WAIT;
      OUT_WAIT: begin
        if (out_done)           state_next = DONE;
        else if (timer_expired) state_next = ERROR;
      end
      DONE:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // Registered output decodes of the upcoming state, so every output is glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_start <= 1'b0;
      cdf_start  <= 1'b0;
      out_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      hist_start <= (state_next == HIST_START);
      cdf_start  <= (state_next == CDF_START);
      out_start  <= (state_next == OUT_START);
      busy       <= (state_next != IDLE) && (state_next != ERROR);
      done       <= (state_next == DONE);
      error      <= (state_next == ERROR);
    end
  end

  // Phase timer: zeroed in each START state so every WAIT begins at 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_timer <= 32'd0;
    end else begin
      case (state)
        HIST_START, CDF_START, OUT_START: phase_timer <= 32'd0;
        HIST_WAIT, CDF_WAIT, OUT_WAIT:    phase_timer <= phase_timer + 32'd1;
        default:                          phase_timer <= phase_timer;
      endcase
    end
  end

  // CdfMin snoops the CDF write stream; zero entries never qualify, and it freezes outside CDF_WAIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      CdfMin <= 8'hFF;
    end else if (state == CDF_START) begin
      CdfMin <= 8'hFF;
    end else if ((state == CDF_WAIT) && cdf_valid &&
                 (cdf_value != 8'd0) && (cdf_value < CdfMin)) begin
      CdfMin <= cdf_value;
    end
  end

  // Run cycle counter: restarts when a run is accepted, saturates rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= 32'd0;
    end else if (go_accepted) begin
      cycle_count <= 32'd0;
    end else if (in_run && (cycle_count != 32'hFFFF_FFFF)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_equalization_sequencer.sv
// tb_equalization_sequencer: table-driven, scoreboarded bench for equalization_sequencer.
module tb_equalization_sequencer;

  typedef enum int {P_IDLE, P_HS, P_HW, P_CS, P_CW, P_OS, P_OW, P_DONE, P_ERR} ph_t;

  typedef struct {
    logic [4:0]  ins;
    logic        cv;
    logic [7:0]  val;
    ph_t         ph;
    logic [7:0]  min;
    logic [31:0] cnt;
  } vec_t;

  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_RST  = 5'b10000;
  localparam logic [4:0] I_GO   = 5'b01000;
  localparam logic [4:0] I_HD   = 5'b00100;
  localparam logic [4:0] I_CD   = 5'b00010;
  localparam logic [4:0] I_OD   = 5'b00001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        hist_done = 1'b0;
  logic        cdf_done = 1'b0;
  logic        out_done = 1'b0;
  logic        cdf_valid = 1'b0;
  logic [7:0]  cdf_value = 8'd0;
  logic        hist_start, cdf_start, out_start, busy, done, error;
  logic [7:0]  CdfMin;
  logic [31:0] cycle_count;

  int   n_checks = 0;
  int   n_fail = 0;
  int   step_no = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  equalization_sequencer #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .go(go),
    .hist_start(hist_start), .hist_done(hist_done),
    .cdf_start(cdf_start), .cdf_done(cdf_done),
    .cdf_valid(cdf_valid), .cdf_value(cdf_value),
    .out_start(out_start), .out_done(out_done),
    .CdfMin(CdfMin), .busy(busy), .done(done), .error(error),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [4:0] ins, input logic cv, input logic [7:0] val,
                              input ph_t ph, input logic [7:0] min, input logic [31:0] cnt);
    vec_t v;
    v.ins = ins; v.cv = cv; v.val = val; v.ph = ph; v.min = min; v.cnt = cnt;
    return v;
  endfunction

  function automatic vec_t st(input logic [4:0] ins, input ph_t ph,
                              input logic [7:0] min, input logic [31:0] cnt);
    return mk(ins, 1'b0, 8'd0, ph, min, cnt);
  endfunction

  // {hist_start, cdf_start, out_start, busy, done, error} expected in each phase
  function automatic logic [5:0] expected_flags(input ph_t ph);
    case (ph)
      P_HS:    return 6'b100100;
      P_HW:    return 6'b000100;
      P_CS:    return 6'b010100;
      P_CW:    return 6'b000100;
      P_OS:    return 6'b001100;
      P_OW:    return 6'b000100;
      P_DONE:  return 6'b000110;
      P_ERR:   return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at step %0d: got %0h, expected %0h", name, step_no, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset     = v.ins[4];
    go        = v.ins[3];
    hist_done = v.ins[2];
    cdf_done  = v.ins[1];
    out_done  = v.ins[0];
    cdf_valid = v.cv;
    cdf_value = v.val;
    exp_q.push_back(v);
  endtask

  task automatic check_output();
    vec_t       e;
    logic [5:0] f;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard at step %0d: got empty queue, expected an entry", step_no);
    end else begin
      e = exp_q.pop_front();
      f = expected_flags(e.ph);
      cmp("hist_start",  {31'd0, hist_start}, {31'd0, f[5]});
      cmp("cdf_start",   {31'd0, cdf_start},  {31'd0, f[4]});
      cmp("out_start",   {31'd0, out_start},  {31'd0, f[3]});
      cmp("busy",        {31'd0, busy},       {31'd0, f[2]});
      cmp("done",        {31'd0, done},       {31'd0, f[1]});
      cmp("error",       {31'd0, error},      {31'd0, f[0]});
      cmp("CdfMin",      {24'd0, CdfMin},     {24'd0, e.min});
      cmp("cycle_count", cycle_count,         e.cnt);
    end
    step_no++;
  endtask

  task automatic step(input vec_t v);
    apply_stimulus(v);
    @(posedge clock);
    #1;
    check_output();
  endtask

  initial begin
    // nominal run, each done three cycles after its start pulse
    tbl.push_back(st(I_GO,   P_HS,   8'hFF, 0));
    tbl.push_back(st(I_NONE, P_HW,   8'hFF, 1));
    tbl.push_back(st(I_NONE, P_HW,   8'hFF, 2));
    tbl.push_back(st(I_NONE, P_HW,   8'hFF, 3));
    tbl.push_back(st(I_HD,   P_CS,   8'hFF, 4));
    tbl.push_back(st(I_NONE, P_CW,   8'hFF, 5));
    tbl.push_back(mk(I_NONE, 1'b1, 8'd30, P_CW, 8'd30, 6));
    tbl.push_back(mk(I_NONE, 1'b1, 8'd50, P_CW, 8'd30, 7));
    tbl.push_back(st(I_CD,   P_OS,   8'd30, 8));
    tbl.push_back(st(I_NONE, P_OW,   8'd30, 9));
    tbl.push_back(st(I_NONE, P_OW,   8'd30, 10));
    tbl.push_back(st(I_NONE, P_OW,   8'd30, 11));
    tbl.push_back(st(I_OD,   P_DONE, 8'd30, 12));
    tbl.push_back(st(I_NONE, P_IDLE, 8'd30, 12));
    // CdfMin tracking: 0,0,40,17,17,200 valid, then 5 with valid low
    tbl.push_back(st(I_GO,   P_HS,   8'd30, 0));
    tbl.push_back(st(I_NONE, P_HW,   8'd30, 1));
    tbl.push_back(st(I_HD,   P_CS,   8'd30, 2));
    tbl.push_back(st(I_NONE, P_CW,   8'hFF, 3));
    tbl.push_back(mk(I_NONE, 1'b1, 8'd0,   P_CW, 8'hFF, 4));
    tbl.push_back(mk(I_NONE, 1'b1, 8'd0,   P_CW, 8'hFF, 5));
    tbl.push_back(mk(I_NONE, 1'b1, 8'd40,  P_CW, 8'd40, 6));
    tbl.push_back(mk(I_NONE, 1'b1, 8'd17,  P_CW, 8'd17, 7));
    tbl.push_back(mk(I_NONE, 1'b1, 8'd17,  P_CW, 8'd17, 8));
    tbl.push_back(mk(I_NONE, 1'b1, 8'd200, P_CW, 8'd17, 9));
    tbl.push_back(mk(I_NONE, 1'b0, 8'd5,   P_CW, 8'd17, 10));
    tbl.push_back(st(I_CD,   P_OS,   8'd17, 11));
    tbl.push_back(st(I_NONE, P_OW,   8'd17, 12));
    tbl.push_back(st(I_OD,   P_DONE, 8'd17, 13));
    tbl.push_back(st(I_NONE, P_IDLE, 8'd17, 13));
    // minimum run, all-zero CDF stream leaves CdfMin at FF
    tbl.push_back(st(I_GO,   P_HS,   8'd17, 0));
    tbl.push_back(st(I_NONE, P_HW,   8'd17, 1));
    tbl.push_back(st(I_HD,   P_CS,   8'd17, 2));
    tbl.push_back(st(I_NONE, P_CW,   8'hFF, 3));
    tbl.push_back(mk(I_CD, 1'b1, 8'd0, P_OS, 8'hFF, 4));
    tbl.push_back(st(I_NONE, P_OW,   8'hFF, 5));
    tbl.push_back(st(I_OD,   P_DONE, 8'hFF, 6));
    tbl.push_back(st(I_NONE, P_IDLE, 8'hFF, 6));

    // reset dominates a simultaneous go
    step(st(I_RST | I_GO, P_IDLE, 8'hFF, 0));
    step(st(I_RST,        P_IDLE, 8'hFF, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // spurious dones and a mid-run go are ignored
    step(st(I_GO | I_HD, P_HS,   8'hFF, 0));
    step(st(I_HD,        P_HW,   8'hFF, 1));
    step(st(I_CD | I_GO, P_HW,   8'hFF, 2));
    step(st(I_GO,        P_HW,   8'hFF, 3));
    step(st(I_HD,        P_CS,   8'hFF, 4));
    step(st(I_CD,        P_CW,   8'hFF, 5));
    step(st(I_OD | I_HD, P_CW,   8'hFF, 6));
    step(st(I_CD,        P_OS,   8'hFF, 7));
    step(st(I_NONE,      P_OW,   8'hFF, 8));
    step(st(I_OD,        P_DONE, 8'hFF, 9));
    step(st(I_NONE,      P_IDLE, 8'hFF, 9));

    // timeout in CDF_WAIT: ERROR 16 cycles after entry
    step(st(I_GO,   P_HS, 8'hFF, 0));
    step(st(I_NONE, P_HW, 8'hFF, 1));
    step(st(I_HD,   P_CS, 8'hFF, 2));
    step(st(I_NONE, P_CW, 8'hFF, 3));
    for (int i = 0; i < 15; i++) step(st(I_NONE, P_CW, 8'hFF, 32'(4 + i)));
    step(st(I_NONE,               P_ERR, 8'hFF, 19));
    step(st(I_HD | I_CD | I_OD,   P_ERR, 8'hFF, 19));
    // go from ERROR restarts; hist_done at timer 15 wins over the timeout
    step(st(I_GO,   P_HS, 8'hFF, 0));
    step(st(I_NONE, P_HW, 8'hFF, 1));
    for (int i = 0; i < 15; i++) step(st(I_NONE, P_HW, 8'hFF, 32'(2 + i)));
    step(st(I_HD,   P_CS,   8'hFF, 17));
    step(st(I_NONE, P_CW,   8'hFF, 18));
    step(st(I_CD,   P_OS,   8'hFF, 19));
    step(st(I_NONE, P_OW,   8'hFF, 20));
    step(st(I_OD,   P_DONE, 8'hFF, 21));
    step(st(I_NONE, P_IDLE, 8'hFF, 21));

    // reset during OUT_WAIT together with out_done
    step(st(I_GO,   P_HS, 8'hFF, 0));
    step(st(I_NONE, P_HW, 8'hFF, 1));
    step(st(I_HD,   P_CS, 8'hFF, 2));
    step(st(I_NONE, P_CW, 8'hFF, 3));
    step(mk(I_CD, 1'b1, 8'd99, P_OS, 8'd99, 4));
    step(st(I_NONE,        P_OW,   8'd99, 5));
    step(st(I_RST | I_OD,  P_IDLE, 8'hFF, 0));
    step(st(I_NONE,        P_IDLE, 8'hFF, 0));
    // next run behaves nominally
    step(st(I_GO,   P_HS,   8'hFF, 0));
    step(st(I_NONE, P_HW,   8'hFF, 1));
    step(st(I_HD,   P_CS,   8'hFF, 2));
    step(st(I_NONE, P_CW,   8'hFF, 3));
    step(mk(I_CD, 1'b1, 8'd8, P_OS, 8'd8, 4));
    step(st(I_NONE, P_OW,   8'd8, 5));
    step(st(I_OD,   P_DONE, 8'd8, 6));
    step(st(I_NONE, P_IDLE, 8'd8, 6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
